// File: rtl/serial_word_tx.sv
// Framed parallel-in/serial-out transmitter: start bit, data, optional even parity, stop bit.
// Every serial bit is held for CLKS_PER_BIT clocks; the line idles high.
`timescale 1ns/1ps
module serial_word_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter bit MSB_FIRST    = 1'b0,
  parameter bit PARITY_EN    = 1'b0
) (
  input  logic             clock,
  input  logic             reset_L,
  input  logic [WIDTH-1:0] data,
  input  logic             valid,
  output logic             ready,
  output logic             serial,
  output logic             busy,
  output logic             done,
  output logic [2:0]       dbg_state
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_shift;
  logic [BW-1:0]    r_bit_cnt;
  logic [CW-1:0]    r_clk_cnt;
  logic             r_parity;
  logic             r_done;
  logic             w_bit_end;
  logic             w_accept;
  logic             w_serial;

  // Handshake: a word transfers on a rising edge where valid and ready are both 1;
  // ready is high only in IDLE, and data is captured only at that edge.
  assign w_bit_end = (r_clk_cnt == CNT_LAST);
  assign w_accept  = (r_state == S_IDLE) && valid;

  always_comb begin
    w_next   = r_state;
    w_serial = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (valid) w_next = S_START;
      end
      S_START: begin
        w_serial = 1'b0;
        if (w_bit_end) w_next = S_DATA;
      end
      S_DATA: begin
        w_serial = MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0];
        if (w_bit_end && (r_bit_cnt == BIT_LAST))
          w_next = PARITY_EN ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        w_serial = r_parity;
        if (w_bit_end) w_next = S_STOP;
      end
      S_STOP: begin
        if (w_bit_end) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_clk_cnt <= '0;
      r_parity  <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= (r_state == S_STOP) && w_bit_end;
      if (w_accept) begin
        r_shift   <= data;
        r_parity  <= ^data;
        r_clk_cnt <= '0;
        r_bit_cnt <= '0;
      end else if (r_state != S_IDLE) begin
        r_clk_cnt <= w_bit_end ? '0 : r_clk_cnt + 1'b1;
        // The outgoing bit always sits at the serial end of the register.
        if ((r_state == S_DATA) && w_bit_end) begin
          r_bit_cnt <= r_bit_cnt + 1'b1;
          r_shift   <= MSB_FIRST ? (r_shift << 1) : (r_shift >> 1);
        end
      end
    end
  end

  assign ready     = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign serial    = w_serial;
  assign dbg_state = r_state;

endmodule
